// File: rtl/main_mem_arbiter_pkg.sv
// Shared types, widths and helpers for the unified main-memory arbiter.
package main_mem_arbiter_pkg;

   localparam int unsigned MEM_ADDR_W_DEF  = 8;
   localparam int unsigned D_BASE_LINE_DEF = 64;
   localparam int unsigned LINE_W          = 128;
   localparam int unsigned WORD_W          = 32;
   localparam int unsigned WORDS_PER_LINE  = 4;
   localparam int unsigned WORD_IDX_W      = 2;
   localparam int unsigned BLK_ADDR_W      = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } gnt_e;

   // Latched copy of the granted request, used for the whole transfer.
   typedef struct packed {
      gnt_e                  gnt;
      logic                  write;
      logic [WORD_IDX_W-1:0] word;
      logic [WORD_W-1:0]     wdata;
   } xfer_t;

   // Pick one 32-bit word out of a memory line.
   function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0]     line,
                                                   input logic [WORD_IDX_W-1:0] idx);
      case (idx)
         2'd0:    line_word = line[31:0];
         2'd1:    line_word = line[63:32];
         2'd2:    line_word = line[95:64];
         default: line_word = line[127:96];
      endcase
   endfunction

   // One-hot word enable for a word index.
   function automatic logic [WORDS_PER_LINE-1:0] word_onehot(input logic [WORD_IDX_W-1:0] idx);
      word_onehot = WORDS_PER_LINE'(1) << idx;
   endfunction

endpackage

// File: rtl/main_mem_arbiter_grant_sel.sv
// Combinational grant pick between icache and dcache requests.
// ARB_RR_EN defined: ties go to rr_ptr (side not granted last); otherwise dcache wins ties.
module main_mem_arbiter_grant_sel
   import main_mem_arbiter_pkg::*;
(
   input  logic i_req,
   input  logic d_req,
   input  gnt_e rr_ptr,
   output logic gnt_vld_c,
   output gnt_e gnt_c
);

   assign gnt_vld_c = i_req | d_req;

`ifdef ARB_RR_EN
   // Round-robin: only a tie consults the pointer.
   always_comb begin
      gnt_c = GNT_I;
      if (i_req && d_req) begin
         gnt_c = rr_ptr;
      end else if (d_req) begin
         gnt_c = GNT_D;
      end
   end
`else
   logic rr_ptr_unused;
   assign rr_ptr_unused = (rr_ptr == GNT_D);

   // Fixed priority: dcache always wins.
   always_comb begin
      gnt_c = GNT_I;
      if (d_req) begin
         gnt_c = GNT_D;
      end
   end
`endif

endmodule

// File: rtl/main_mem_arbiter.sv
// Arbiter sharing one 128-bit-line main memory between icache and dcache.
// Build option: define ARB_RR_EN for round-robin tie breaking (default: dcache priority).
module main_mem_arbiter
   import main_mem_arbiter_pkg::*;
#(
   parameter int unsigned           MEM_ADDR_W  = MEM_ADDR_W_DEF,
   parameter logic [MEM_ADDR_W-1:0] D_BASE_LINE = MEM_ADDR_W'(D_BASE_LINE_DEF)
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic                      I_READ,
   input  logic [BLK_ADDR_W-1:0]     I_ADDRESS,
   output logic [LINE_W-1:0]         I_READ_DATA,
   output logic                      I_BUSY_WAIT,
   input  logic                      D_READ,
   input  logic                      D_WRITE,
   input  logic [BLK_ADDR_W-1:0]     D_ADDRESS,
   input  logic [WORD_W-1:0]         D_WRITE_DATA,
   output logic [WORD_W-1:0]         D_READ_DATA,
   output logic                      D_BUSY_WAIT,
   output logic                      MEM_READ,
   output logic                      MEM_WRITE,
   output logic [MEM_ADDR_W-1:0]     MEM_ADDRESS,
   output logic [LINE_W-1:0]         MEM_WRITE_DATA,
   output logic [WORDS_PER_LINE-1:0] MEM_WORD_EN,
   input  logic [LINE_W-1:0]         MEM_READ_DATA,
   input  logic                      MEM_BUSY_WAIT
);

   state_e                    state_q,    state_d;
   xfer_t                     xfer_q,     xfer_d;
   gnt_e                      rr_ptr_q,   rr_ptr_d;
   logic [MEM_ADDR_W-1:0]     addr_q,     addr_d;
   logic                      mem_read_q, mem_read_d;
   logic                      mem_write_q, mem_write_d;
   logic [WORDS_PER_LINE-1:0] word_en_q,  word_en_d;
   logic [LINE_W-1:0]         i_rdata_q,  i_rdata_d;
   logic [WORD_W-1:0]         d_rdata_q,  d_rdata_d;

   logic i_req_c;
   logic d_req_c;
   logic gnt_vld_c;
   gnt_e gnt_c;
   logic wr_c;

   assign i_req_c = I_READ;
   assign d_req_c = D_READ | D_WRITE;

   main_mem_arbiter_grant_sel u_grant_sel (
      .i_req     (i_req_c),
      .d_req     (d_req_c),
      .rr_ptr    (rr_ptr_q),
      .gnt_vld_c (gnt_vld_c),
      .gnt_c     (gnt_c)
   );

   // Next-state, request latch, strobe and read-capture logic.
   always_comb begin
      state_d     = state_q;
      xfer_d      = xfer_q;
      rr_ptr_d    = rr_ptr_q;
      addr_d      = addr_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      word_en_d   = word_en_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      wr_c        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            word_en_d   = '0;
            if (gnt_vld_c) begin
               state_d    = ST_ISSUE;
               xfer_d.gnt = gnt_c;
               rr_ptr_d   = (gnt_c == GNT_I) ? GNT_D : GNT_I;
               if (gnt_c == GNT_I) begin
                  wr_c          = 1'b0;
                  addr_d        = MEM_ADDR_W'(I_ADDRESS);
                  xfer_d.word   = '0;
               end else begin
                  // A simultaneous read and write is treated as a write-back.
                  wr_c          = D_WRITE;
                  addr_d        = D_BASE_LINE + MEM_ADDR_W'(D_ADDRESS[BLK_ADDR_W-1:WORD_IDX_W]);
                  xfer_d.word   = D_ADDRESS[WORD_IDX_W-1:0];
                  xfer_d.wdata  = D_WRITE_DATA;
               end
               xfer_d.write = wr_c;
               mem_read_d   = ~wr_c;
               mem_write_d  = wr_c;
               word_en_d    = wr_c ? word_onehot(xfer_d.word) : '0;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (!MEM_BUSY_WAIT) begin
               state_d     = ST_DONE;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               word_en_d   = '0;
               if (!xfer_q.write) begin
                  if (xfer_q.gnt == GNT_I) begin
                     i_rdata_d = MEM_READ_DATA;
                  end else begin
                     d_rdata_d = line_word(MEM_READ_DATA, xfer_q.word);
                  end
               end
            end
         end
         default: begin
            state_d     = ST_IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            word_en_d   = '0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q     <= ST_IDLE;
         xfer_q      <= '{gnt: GNT_I, write: 1'b0, word: '0, wdata: '0};
         rr_ptr_q    <= GNT_I;
         addr_q      <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         word_en_q   <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         xfer_q      <= xfer_d;
         rr_ptr_q    <= rr_ptr_d;
         addr_q      <= addr_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         word_en_q   <= word_en_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   // Release only the granted requester, and only in DONE.
   assign I_BUSY_WAIT = i_req_c & ~((state_q == ST_DONE) && (xfer_q.gnt == GNT_I));
   assign D_BUSY_WAIT = d_req_c & ~((state_q == ST_DONE) && (xfer_q.gnt == GNT_D));

   assign MEM_READ       = mem_read_q;
   assign MEM_WRITE      = mem_write_q;
   assign MEM_ADDRESS    = addr_q;
   assign MEM_WORD_EN    = word_en_q;
   assign MEM_WRITE_DATA = {WORDS_PER_LINE{xfer_q.wdata}};
   assign I_READ_DATA    = i_rdata_q;
   assign D_READ_DATA    = d_rdata_q;

endmodule
